// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with bounded lock that shares one single-port data memory
// between two requesters. It returns registered read data and keeps per-requester wait counters.
module dmem_arbiter #(
    parameter int DEPTH    = 64,
    parameter int LOCK_MAX = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             lock0,
    input  logic             lock1,
    input  logic             we0,
    input  logic             we1,
    input  logic [31:0]      addr0,
    input  logic [31:0]      addr1,
    input  logic [31:0]      wdata0,
    input  logic [31:0]      wdata1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rvalid0,
    output logic             rvalid1,
    output logic [31:0]      rdata0,
    output logic [31:0]      rdata1,
    output logic             err0,
    output logic             err1,
    output logic             mem_we,
    output logic [31:0]      mem_a,
    output logic [31:0]      mem_wd,
    input  logic [31:0]      mem_rd,
    output logic [CNT_W-1:0] wait0,
    output logic [CNT_W-1:0] wait1
);

    localparam int BW = $clog2(LOCK_MAX + 1);

    logic          last;
    logic          owner_lock;
    logic [BW-1:0] beats;
    logic          keep_last;
    logic          any_gnt;
    logic          sel_we;
    logic          sel_lock;
    logic          in0;
    logic          in1;
    logic          sel_in;

    function automatic logic in_range(input logic [31:0] a);
        logic [31:0] word;
        word = {2'b00, a[31:2]};
        return word < 32'(DEPTH);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [BW-1:0] sat_beats(input logic [BW-1:0] v);
        return (v == BW'(LOCK_MAX)) ? v : v + BW'(1);
    endfunction

    assign keep_last = owner_lock && (beats < BW'(LOCK_MAX));

    // Grant is combinational from the requests; held low while reset is asserted
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset) begin
            if (req0 && req1) begin
                gnt0 = keep_last ? !last : last;
                gnt1 = !gnt0;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign in0      = in_range(addr0);
    assign in1      = in_range(addr1);
    assign any_gnt  = gnt0 || gnt1;
    assign sel_we   = gnt1 ? we1 : we0;
    assign sel_lock = gnt1 ? lock1 : lock0;
    assign sel_in   = gnt1 ? in1 : in0;
    assign mem_a    = gnt1 ? addr1 : addr0;
    assign mem_wd   = gnt1 ? wdata1 : wdata0;
    assign mem_we   = any_gnt && sel_we && sel_in;

    // Acceptance edge: response registers, wait counters and arbitration state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            wait0      <= '0;
            wait1      <= '0;
            last       <= 1'b1;
            owner_lock <= 1'b0;
            beats      <= '0;
        end else begin
            rvalid0 <= gnt0 && !we0;
            rvalid1 <= gnt1 && !we1;
            err0    <= gnt0 && !in0;
            err1    <= gnt1 && !in1;
            if (gnt0 && !we0) rdata0 <= in0 ? mem_rd : '0;
            if (gnt1 && !we1) rdata1 <= in1 ? mem_rd : '0;
            if (req0 && !gnt0) wait0 <= sat_inc(wait0);
            if (req1 && !gnt1) wait1 <= sat_inc(wait1);
            if (any_gnt) begin
                beats      <= ((gnt1 == last) && owner_lock) ? sat_beats(beats) : BW'(1);
                last       <= gnt1;
                owner_lock <= sel_lock;
            end else begin
                beats      <= '0;
                owner_lock <= 1'b0;
            end
        end
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port data memory between the processor's data port (requester 0) and a secondary bus master (requester 1, e.g. a loader/DMA engine). It sits between the requesters and the data memory, selects one transaction per cycle with round-robin priority and optional bounded locking, drives the memory port, and returns registered read data with a valid strobe. It also keeps saturating per-requester wait-cycle counters for performance debug.

## Interface
- DEPTH, 64: memory depth in 32-bit words; word index is addr[31:2].
- LOCK_MAX, 4: maximum consecutive grants to one locked requester while the other is waiting (≥1).
- CNT_W, 16: width of each wait-cycle counter.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req0, req1  in  1  request; held until granted.
- lock0, lock1  in  1  request priority retention while req is high.
- we0, we1  in  1  1 = write, 0 = read.
- addr0, addr1  in  32  byte address, word-aligned.
- wdata0, wdata1  in  32  write data.
- gnt0, gnt1  out  1  grant (combinational); the transaction is accepted at the clock edge where req&gnt=1.
- rvalid0, rvalid1  out  1  read data valid, one-cycle pulse.
- rdata0, rdata1  out  32  registered read data.
- err0, err1  out  1  out-of-range pulse, aligned with rvalid/write completion.
- mem_we  out  1  memory write enable.
- mem_a, mem_wd  out  32  memory address, write data.
- mem_rd  in  32  memory read data (combinational read).
- wait0, wait1  out  CNT_W  saturating counts of cycles with req high and gnt low.

## Operation
- State: last (ID of the last granted requester), owner_lock (1 if the last grant carried lock), beats (lock run-length counter, 0..LOCK_MAX), plus per-requester response registers and wait counters.
- Grant selection, evaluated each cycle when reset=1:
  - Neither requests: no grant; mem_we=0.
  - Exactly one requests: that requester is granted.
  - Both request and owner_lock=1 with beats<LOCK_MAX: requester `last` is granted again.
  - Both request otherwise: requester ≠ last is granted (round-robin).
- At most one of gnt0/gnt1 is high in any cycle.
- Memory drive: mem_a and mem_wd come from the granted requester. mem_we = gnt & we & in_range. When there is no grant, mem_a=addr0, mem_wd=wdata0, mem_we=0.
- Range check: in_range = (addr[31:2] < DEPTH).
  - Out-of-range write: write is suppressed; err pulses in the next cycle.
  - Out-of-range read: rdata=0, rvalid=1, and err=1 in the next cycle.
- On an accepted transaction at the edge:
  - last ← granted ID; owner_lock ← lock of the granted requester.
  - beats ← beats+1 if the same requester was granted with lock, else 1.
  - Read: rdata_k ← mem_rd (or 0 if out of range); rvalid_k ← 1.
- rvalid/err clear in the following cycle unless another read or error is accepted. rdata holds its value until the next read by the same requester.
- A requester that drops lock, or is not granted, resets the lock run: owner_lock ← 0.
- Wait counter k increments on every edge with req_k=1 and gnt_k=0, and saturates at 2^CNT_W−1.

## Timing
- Reset (reset=0, asynchronous) clears:
  - gnt0/1 forced 0, mem_we=0.
  - rvalid0/1=0, err0/1=0, rdata0/1=0, wait0/1=0.
  - last=1 (so requester 0 wins the first contention), owner_lock=0, beats=0.
- Reset deassertion is sampled at clk edges. Grants may appear in the first cycle with reset=1.
- Latency:
  - Grant: 0 cycles (combinational from req).
  - Write: takes effect at the acceptance edge.
  - Read: rvalid/rdata valid in the cycle after acceptance. A 1-read-per-cycle stream is sustainable.
- Reset asserted mid-transaction: the pending response is discarded (rvalid stays 0), and no write occurs at or after the reset edge.
- Simultaneous write by one requester and a read by the other is impossible (one grant per cycle). The losing request stays pending, with no loss.
- A read of an address written in the previous cycle returns the new data.

## Test plan
- Reset: hold reset=0 with req0=req1=1 → gnt0=gnt1=0, mem_we=0, all rvalid/err/wait=0. Release reset → gnt0=1 first.
- Alternation: req0=req1=1 continuously, lock=0, reads to 0x10 and 0x20 → grants alternate 0,1,0,1. Each rvalid pulses one cycle after its grant, and wait0/wait1 increase by 1 every two cycles.
- Write then read: requester 1 writes 0xDEADBEEF to 0x08, then requester 0 reads 0x08 in the next cycle → rdata0=0xDEADBEEF with rvalid0=1.
- Lock bound (LOCK_MAX=4): lock0=1, both requesting continuously → requester 0 gets 4 consecutive grants, then requester 1 gets 1, then requester 0 again.
- Out of range: requester 0 writes 0x100 (word 64) → mem_we=0 and err0 pulses. A read of 0x100 → rdata0=0, rvalid0=1, err0=1.
- Counter saturation (CNT_W=4): hold req1=1 while requester 0 is locked, with LOCK_MAX raised, for >15 cycles → wait1 stays at 15.
